// File: rtl/bsg_mem_1rw_sync_req_adapter_pkg.sv
// Constants and helpers shared by the 1rw sync RAM request adapter.
// No ports; provides the response buffer depth and a safe clog2.
package bsg_mem_1rw_sync_req_adapter_pkg;

  localparam int fifo_els_lp = 2;

  function automatic int safe_clog2(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1rw_sync_req_adapter_two_fifo.sv
// Two-entry response buffer. The caller tracks occupancy and never
// overfills it.
// Ports:
//   clk_i, reset_n_i   clock, sync active-low reset
//   v_i, data_i        enqueue strobe and data
//   yumi_i             dequeue strobe
//   data_o             head entry
module bsg_mem_1rw_sync_req_adapter_two_fifo
  import bsg_mem_1rw_sync_req_adapter_pkg::*;
  #(parameter int width_p = 8)
  (input  logic               clk_i
  ,input  logic               reset_n_i
  ,input  logic               v_i
  ,input  logic [width_p-1:0] data_i
  ,input  logic               yumi_i
  ,output logic [width_p-1:0] data_o
  );

  logic [width_p-1:0] mem_r [fifo_els_lp];
  logic               wptr_r;
  logic               rptr_r;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      wptr_r <= 1'b0;
      rptr_r <= 1'b0;
    end else begin
      if (v_i)    wptr_r <= ~wptr_r;
      if (yumi_i) rptr_r <= ~rptr_r;
    end
  end

  // Storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (v_i) mem_r[wptr_r] <= data_i;
  end

  assign data_o = mem_r[rptr_r];

endmodule

// File: rtl/bsg_mem_1rw_sync_req_adapter.sv
// Drives a 1rw sync RAM from a valid/ready request stream and returns
// read data on a valid/ready response stream without losing data.
// Ports:
//   clk_i, reset_n_i          clock, sync active-low reset
//   v_i,w_i,addr_i,data_i     request; ready_and_o accepts it
//   v_o,data_o,ready_and_i    read response stream
//   mem_v_o,mem_w_o,
//   mem_addr_o,mem_data_o     RAM control / write data
//   mem_data_i                RAM read data, one cycle after a read
module bsg_mem_1rw_sync_req_adapter
  import bsg_mem_1rw_sync_req_adapter_pkg::*;
  #(parameter int width_p       = 8
   ,parameter int els_p         = 16
   ,parameter int addr_width_lp = safe_clog2(els_p)
   )
  (input  logic                     clk_i
  ,input  logic                     reset_n_i
  ,input  logic                     v_i
  ,input  logic                     w_i
  ,input  logic [addr_width_lp-1:0] addr_i
  ,input  logic [width_p-1:0]       data_i
  ,output logic                     ready_and_o
  ,output logic                     v_o
  ,output logic [width_p-1:0]       data_o
  ,input  logic                     ready_and_i
  ,output logic                     mem_v_o
  ,output logic                     mem_w_o
  ,output logic [addr_width_lp-1:0] mem_addr_o
  ,output logic [width_p-1:0]       mem_data_o
  ,input  logic [width_p-1:0]       mem_data_i
  );

  logic               acc;
  logic               rd_inflight_r;
  logic [1:0]         count_r;
  logic [1:0]         used;
  logic               has_buf;
  logic               enq;
  logic               deq;
  logic [width_p-1:0] fifo_data;

  // Credits: every buffered or in-flight read holds a slot, so the
  // buffer can always absorb data the consumer refuses.
  assign used        = count_r + {1'b0, rd_inflight_r};
  assign ready_and_o = reset_n_i & (used < 2'(fifo_els_lp));
  assign acc         = v_i & ready_and_o;

  assign mem_v_o    = acc;
  assign mem_w_o    = w_i;
  assign mem_addr_o = addr_i;
  assign mem_data_o = data_i;

  // Buffered data is older than in-flight data, so it goes first.
  assign has_buf = (count_r != 2'd0);
  assign v_o     = has_buf | rd_inflight_r;
  assign data_o  = has_buf ? fifo_data : mem_data_i;

  assign enq = rd_inflight_r & (has_buf | ~ready_and_i);
  assign deq = v_o & ready_and_i & has_buf;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rd_inflight_r <= 1'b0;
      count_r       <= 2'd0;
    end else begin
      rd_inflight_r <= acc & ~w_i;
      case ({enq, deq})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  bsg_mem_1rw_sync_req_adapter_two_fifo #(
    .width_p(width_p)
  ) fifo (
    .clk_i    (clk_i)
   ,.reset_n_i(reset_n_i)
   ,.v_i      (enq)
   ,.data_i   (mem_data_i)
   ,.yumi_i   (deq)
   ,.data_o   (fifo_data)
  );

endmodule

// File: tb/tb_bsg_mem_1rw_sync_req_adapter.sv
// Self-checking bench for bsg_mem_1rw_sync_req_adapter.
// Behavioural RAM stub plus scoreboard of expected read data.
module tb_bsg_mem_1rw_sync_req_adapter;

  localparam int W = 8;
  localparam int E = 16;
  localparam int A = 4;

  logic         clk = 1'b0;
  logic         reset_n_i;
  logic         v_i;
  logic         w_i;
  logic [A-1:0] addr_i;
  logic [W-1:0] data_i;
  logic         ready_and_o;
  logic         v_o;
  logic [W-1:0] data_o;
  logic         ready_and_i;
  logic         mem_v_o;
  logic         mem_w_o;
  logic [A-1:0] mem_addr_o;
  logic [W-1:0] mem_data_o;
  logic [W-1:0] mem_data_i;

  logic [W-1:0] ram [E];
  logic [W-1:0] model [E];
  logic [W-1:0] sb [$];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  bsg_mem_1rw_sync_req_adapter #(
    .width_p(W)
   ,.els_p  (E)
  ) dut (
    .clk_i      (clk)
   ,.reset_n_i  (reset_n_i)
   ,.v_i        (v_i)
   ,.w_i        (w_i)
   ,.addr_i     (addr_i)
   ,.data_i     (data_i)
   ,.ready_and_o(ready_and_o)
   ,.v_o        (v_o)
   ,.data_o     (data_o)
   ,.ready_and_i(ready_and_i)
   ,.mem_v_o    (mem_v_o)
   ,.mem_w_o    (mem_w_o)
   ,.mem_addr_o (mem_addr_o)
   ,.mem_data_o (mem_data_o)
   ,.mem_data_i (mem_data_i)
  );

  // RAM stub; read port shows garbage on non-read cycles
  always @(posedge clk) begin
    if (mem_v_o && mem_w_o) ram[mem_addr_o] <= mem_data_o;
    if (mem_v_o && !mem_w_o) mem_data_i <= ram[mem_addr_o];
    else mem_data_i <= W'($urandom);
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset_n_i) begin
      sb.delete();
    end else begin
      total++;
      if (v_o !== (sb.size() != 0)) begin
        $display("FAIL resp_valid: got %b expected %b",
                 v_o, sb.size() != 0);
      end else passed++;
      if (v_o && ready_and_i && sb.size() != 0) begin
        logic [W-1:0] e;
        e = sb.pop_front();
        total++;
        if (data_o !== e)
          $display("FAIL resp_data: got %h expected %h", data_o, e);
        else passed++;
      end
      if (v_i && ready_and_o) begin
        if (w_i) model[addr_i] = data_i;
        else sb.push_back(model[addr_i]);
      end
      total++;
      if (int'(dut.count_r) + int'(dut.rd_inflight_r) > 2)
        $display("FAIL credit: got %0d expected <=2",
                 int'(dut.count_r) + int'(dut.rd_inflight_r));
      else passed++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [A-1:0] a,
                            input logic [W-1:0] d);
    int g;
    g = 0;
    v_i = 1'b1; w_i = 1'b1; addr_i = a; data_i = d;
    while (!ready_and_o && g < 20) begin
      step();
      g++;
    end
    total++;
    if (!ready_and_o)
      $display("FAIL write_accept: got %b expected 1", ready_and_o);
    else passed++;
    step();
    v_i = 1'b0; w_i = 1'b0;
  endtask

  task automatic test_reset();
    reset_n_i = 1'b0; v_i = 1'b1; w_i = 1'b0; addr_i = '0;
    data_i = '0; ready_and_i = 1'b1;
    step(); step();
    total++;
    if (ready_and_o !== 1'b0)
      $display("FAIL rst_ready: got %b expected 0", ready_and_o);
    else passed++;
    total++;
    if (mem_v_o !== 1'b0)
      $display("FAIL rst_mem_v: got %b expected 0", mem_v_o);
    else passed++;
    total++;
    if (v_o !== 1'b0)
      $display("FAIL rst_v_o: got %b expected 0", v_o);
    else passed++;
    reset_n_i = 1'b1; w_i = 1'b1; addr_i = 4'd0; data_i = 8'h3C;
    #1;
    total++;
    if (ready_and_o !== 1'b1)
      $display("FAIL rel_ready: got %b expected 1", ready_and_o);
    else passed++;
    total++;
    if (mem_v_o !== 1'b1)
      $display("FAIL rel_mem_v: got %b expected 1", mem_v_o);
    else passed++;
    step();
    v_i = 1'b0; w_i = 1'b0;
  endtask

  task automatic test_raw();
    write_word(4'd3, 8'hA5);
    v_i = 1'b1; w_i = 1'b0; addr_i = 4'd3;
    #1;
    total++;
    if ({mem_v_o, mem_w_o, mem_addr_o} !== {2'b10, 4'd3})
      $display("FAIL raw_mem_pins: got %b expected %b",
               {mem_v_o, mem_w_o, mem_addr_o}, {2'b10, 4'd3});
    else passed++;
    step();
    v_i = 1'b0;
    total++;
    if (v_o !== 1'b1 || data_o !== 8'hA5)
      $display("FAIL raw_resp: got %b/%h expected 1/a5", v_o, data_o);
    else passed++;
    step();
    total++;
    if (v_o !== 1'b0)
      $display("FAIL raw_idle: got %b expected 0", v_o);
    else passed++;
  endtask

  task automatic test_stream();
    logic [W-1:0] e;
    for (int i = 0; i < 8; i++) write_word(A'(i), 8'(i * 17));
    ready_and_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      v_i = 1'b1; w_i = 1'b0; addr_i = A'(i);
      total++;
      if (ready_and_o !== 1'b1)
        $display("FAIL stream_ready: got %b expected 1", ready_and_o);
      else passed++;
      if (i > 0) begin
        e = 8'((i - 1) * 17);
        total++;
        if (v_o !== 1'b1 || data_o !== e)
          $display("FAIL stream_resp: got %b/%h expected 1/%h",
                   v_o, data_o, e);
        else passed++;
      end
      step();
    end
    v_i = 1'b0;
    total++;
    if (v_o !== 1'b1 || data_o !== 8'h77)
      $display("FAIL stream_last: got %b/%h expected 1/77", v_o, data_o);
    else passed++;
    step();
    total++;
    if (v_o !== 1'b0)
      $display("FAIL stream_idle: got %b expected 0", v_o);
    else passed++;
  endtask

  task automatic test_back_pressure();
    logic [3:0] exp_rdy;
    int n;
    exp_rdy = 4'b0011;
    n = 0;
    ready_and_i = 1'b0;
    for (int c = 0; c < 4; c++) begin
      v_i = 1'b1; w_i = 1'b0; addr_i = A'(4 + n);
      total++;
      if (ready_and_o !== exp_rdy[c])
        $display("FAIL bp_ready%0d: got %b expected %b",
                 c, ready_and_o, exp_rdy[c]);
      else passed++;
      if (ready_and_o) n++;
      step();
    end
    ready_and_i = 1'b1; addr_i = A'(4 + n);
    total++;
    if (ready_and_o !== 1'b0 || v_o !== 1'b1 || data_o !== 8'h44)
      $display("FAIL bp_first: got %b/%b/%h expected 0/1/44",
               ready_and_o, v_o, data_o);
    else passed++;
    step();
    total++;
    if (ready_and_o !== 1'b1 || v_o !== 1'b1 || data_o !== 8'h55)
      $display("FAIL bp_recover: got %b/%b/%h expected 1/1/55",
               ready_and_o, v_o, data_o);
    else passed++;
    step();
    v_i = 1'b0;
    total++;
    if (v_o !== 1'b1 || data_o !== 8'h66)
      $display("FAIL bp_third: got %b/%h expected 1/66", v_o, data_o);
    else passed++;
    step();
    total++;
    if (v_o !== 1'b0)
      $display("FAIL bp_idle: got %b expected 0", v_o);
    else passed++;
  endtask

  task automatic test_mixed();
    int g;
    logic done;
    for (int k = 0; k < 40; k++) begin
      v_i = 1'b1; w_i = (k % 2 == 0); addr_i = 4'd9;
      data_i = 8'($urandom);
      g = 0; done = 1'b0;
      while (!done && g < 64) begin
        ready_and_i = 1'($urandom);
        done = ready_and_o;
        step();
        g++;
      end
      total++;
      if (!done) $display("FAIL mixed_accept: got 0 expected 1");
      else passed++;
    end
    v_i = 1'b0; ready_and_i = 1'b1;
    repeat (4) step();
    total++;
    if (sb.size() != 0 || v_o !== 1'b0)
      $display("FAIL mixed_drain: got %0d/%b expected 0/0",
               sb.size(), v_o);
    else passed++;
  endtask

  task automatic test_reset_mid();
    ready_and_i = 1'b0;
    v_i = 1'b1; w_i = 1'b0; addr_i = 4'd1;
    step(); step();
    v_i = 1'b0;
    step(); step();
    total++;
    if (ready_and_o !== 1'b0 || v_o !== 1'b1)
      $display("FAIL mid_full: got %b/%b expected 0/1",
               ready_and_o, v_o);
    else passed++;
    reset_n_i = 1'b0; v_i = 1'b1;
    #1;
    total++;
    if (ready_and_o !== 1'b0 || mem_v_o !== 1'b0)
      $display("FAIL mid_rst_pins: got %b/%b expected 0/0",
               ready_and_o, mem_v_o);
    else passed++;
    step();
    reset_n_i = 1'b1; v_i = 1'b0; ready_and_i = 1'b1;
    #1;
    total++;
    if (v_o !== 1'b0 || ready_and_o !== 1'b1 || dut.count_r !== 2'd0)
      $display("FAIL mid_after: got %b/%b/%0d expected 0/1/0",
               v_o, ready_and_o, dut.count_r);
    else passed++;
    for (int c = 0; c < 3; c++) begin
      step();
      total++;
      if (v_o !== 1'b0)
        $display("FAIL mid_stale%0d: got %b expected 0", c, v_o);
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < E; i++) write_word(A'(i), 8'($urandom));
    for (int c = 0; c < 10000; c++) begin
      reset_n_i   = ($urandom_range(0, 999) != 0);
      v_i         = 1'($urandom);
      w_i         = ($urandom_range(0, 3) == 0);
      addr_i      = A'($urandom);
      data_i      = 8'($urandom);
      ready_and_i = ($urandom_range(0, 3) != 0);
      step();
    end
    reset_n_i = 1'b1; v_i = 1'b0; w_i = 1'b0; ready_and_i = 1'b1;
    repeat (4) step();
    total++;
    if (sb.size() != 0 || v_o !== 1'b0)
      $display("FAIL random_drain: got %0d/%b expected 0/0",
               sb.size(), v_o);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_stream();
    test_back_pressure();
    test_mixed();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
